// File: rtl/vga_pixel_source_if.sv
// -----------------------------------------------------------------------------
// vga_pixel_source_if
// Bundles the pixel-request, framebuffer-RAM, page-swap and RGB signals of the
// VGA pixel source.
//   inX/inY/inRequest     : pixel request from the VGA controller
//   memAddr/memData       : framebuffer RAM read port (data 1 cycle after addr)
//   swapReq/swapAck/page  : page-flip handshake with the game logic
//   outRed/outGreen/outBlue : colour answer to the controller
// The slave modport is the pixel source, the master modport is its environment
// (controller + RAM + game logic).
// -----------------------------------------------------------------------------
interface vga_pixel_source_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [9:0]        inX;
  logic [9:0]        inY;
  logic              inRequest;
  logic [ADDR_W-1:0] memAddr;
  logic [7:0]        memData;
  logic              swapReq;
  logic              swapAck;
  logic              page;
  logic [7:0]        outRed;
  logic [7:0]        outGreen;
  logic [7:0]        outBlue;

  modport master (
    output inX, inY, inRequest, memData, swapReq,
    input  memAddr, swapAck, page, outRed, outGreen, outBlue
  );

  modport slave (
    input  inX, inY, inRequest, memData, swapReq,
    output memAddr, swapAck, page, outRed, outGreen, outBlue
  );
endinterface

// File: rtl/vga_pixel_source.sv
// -----------------------------------------------------------------------------
// vga_pixel_source
// Answers VGA controller pixel requests with RGB read from a double-buffered,
// low-resolution RGB332 framebuffer held in an external synchronous RAM.
// The source image is upscaled by 2^SCALE_SHIFT; requests outside it get
// BORDER_RGB, idle cycles get black. Page flips are requested by the game
// logic and applied only at the first pixel of a frame to avoid tearing.
// Ports:
//   clk25 : 25 MHz pixel clock
//   rstN  : asynchronous active-low reset
//   bus   : vga_pixel_source_if.slave (request, RAM port, swap handshake, RGB)
// -----------------------------------------------------------------------------
module vga_pixel_source #(
  parameter int unsigned SRC_W       = 160,
  parameter int unsigned SRC_H       = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
  input  logic                    clk25,
  input  logic                    rstN,
  vga_pixel_source_if.slave       bus
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_state_t;

  localparam logic [ADDR_W-1:0] C_PAGE_WORDS = ADDR_W'(SRC_W * SRC_H);
  localparam logic [ADDR_W-1:0] C_ROW_WORDS  = ADDR_W'(SRC_W);

  swap_state_t       r_state;
  logic              r_page;
  logic              r_swap_ack;
  logic              r_valid_q;
  logic              r_in_area_q;
  logic [7:0]        r_red;
  logic [7:0]        r_green;
  logic [7:0]        r_blue;

  logic [9:0]        w_sx;
  logic [9:0]        w_sy;
  logic              w_in_area;
  logic              w_frame_start;
  logic              w_page_eff;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [23:0]       w_rgb_mem;

  // RGB332 -> RGB888 by bit replication so full-scale codes map to 8'hFF.
  function automatic logic [23:0] f_expand_332(input logic [7:0] d);
    logic [2:0] r3;
    logic [2:0] g3;
    logic [1:0] b2;
    r3 = d[7:5];
    g3 = d[4:2];
    b2 = d[1:0];
    return {r3, r3, r3[2:1], g3, g3, g3[2:1], b2, b2, b2, b2};
  endfunction

  assign w_sx          = bus.inX >> SCALE_SHIFT;
  assign w_sy          = bus.inY >> SCALE_SHIFT;
  assign w_in_area     = bus.inRequest && (32'(w_sx) < 32'(SRC_W)) && (32'(w_sy) < 32'(SRC_H));
  assign w_frame_start = bus.inRequest && (bus.inX == 10'd0) && (bus.inY == 10'd0);
  // The flipping request already reads from the new page.
  assign w_page_eff    = ((r_state == ST_PENDING) && w_frame_start) ? ~r_page : r_page;
  assign w_rgb_mem     = f_expand_332(bus.memData);

  // Framebuffer read address; forced to zero while held in reset.
  always_comb begin
    w_mem_addr = {ADDR_W{1'b0}};
    if (!rstN) begin
      w_mem_addr = {ADDR_W{1'b0}};
    end else if (w_in_area) begin
      w_mem_addr = (w_page_eff ? C_PAGE_WORDS : {ADDR_W{1'b0}})
                 + (ADDR_W'(w_sy) * C_ROW_WORDS)
                 + ADDR_W'(w_sx);
    end else begin
      w_mem_addr = {ADDR_W{1'b0}};
    end
  end

  // Page-swap FSM with registered page and one-cycle acknowledge.
  always_ff @(posedge clk25 or negedge rstN) begin
    if (!rstN) begin
      r_state    <= ST_IDLE;
      r_page     <= 1'b0;
      r_swap_ack <= 1'b0;
    end else begin
      r_swap_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.swapReq) begin
            r_state <= ST_PENDING;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PENDING: begin
          if (w_frame_start) begin
            r_page     <= ~r_page;
            r_swap_ack <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_state <= ST_PENDING;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Request stage: remembers what the RAM data arriving next cycle belongs to.
  always_ff @(posedge clk25 or negedge rstN) begin
    if (!rstN) begin
      r_valid_q   <= 1'b0;
      r_in_area_q <= 1'b0;
    end else begin
      r_valid_q   <= bus.inRequest;
      r_in_area_q <= w_in_area;
    end
  end

  // Output colour register: black on gaps, border outside, expanded RAM data inside.
  always_ff @(posedge clk25 or negedge rstN) begin
    if (!rstN) begin
      r_red   <= 8'd0;
      r_green <= 8'd0;
      r_blue  <= 8'd0;
    end else if (!r_valid_q) begin
      r_red   <= 8'd0;
      r_green <= 8'd0;
      r_blue  <= 8'd0;
    end else if (!r_in_area_q) begin
      r_red   <= BORDER_RGB[23:16];
      r_green <= BORDER_RGB[15:8];
      r_blue  <= BORDER_RGB[7:0];
    end else begin
      r_red   <= w_rgb_mem[23:16];
      r_green <= w_rgb_mem[15:8];
      r_blue  <= w_rgb_mem[7:0];
    end
  end

  assign bus.memAddr  = w_mem_addr;
  assign bus.swapAck  = r_swap_ack;
  assign bus.page     = r_page;
  assign bus.outRed   = r_red;
  assign bus.outGreen = r_green;
  assign bus.outBlue  = r_blue;

endmodule

// File: tb/tb_vga_pixel_source.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_source
// Directed bench for vga_pixel_source: a synchronous RAM model feeds memData,
// expected colours are queued when a request is driven and compared when the
// corresponding output appears; page/swap state is tracked by a small model.
// -----------------------------------------------------------------------------
module tb_vga_pixel_source;

  localparam int unsigned ADDR_W = 16;
  localparam logic [23:0] BORDER = 24'h20A0C0;

  logic clk25;
  logic rstN;

  vga_pixel_source_if #(.ADDR_W(ADDR_W)) vif ();

  vga_pixel_source #(
    .SRC_W      (160),
    .SRC_H      (120),
    .SCALE_SHIFT(2),
    .ADDR_W     (ADDR_W),
    .BORDER_RGB (BORDER)
  ) dut (
    .clk25(clk25),
    .rstN (rstN),
    .bus  (vif.slave)
  );

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q [$];
  int          checks;
  int          failures;
  bit          m_page;
  bit          m_pending;
  bit          m_ack;

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  // Synchronous framebuffer RAM: data one cycle after the address.
  always @(posedge clk25) vif.memData <= mem[vif.memAddr];

  function automatic logic [23:0] expand(input logic [7:0] d);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = d[7:5];
    g = d[4:2];
    b = d[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb_now();
    return {8'd0, vif.outRed, vif.outGreen, vif.outBlue};
  endfunction

  // One pixel-clock cycle of stimulus plus model update and checks.
  task automatic step(input int x, input int y, input bit req, input bit swp, input int exp_addr);
    bit fs;
    bit peff;
    bit in_area;
    int a;
    logic [23:0] e;
    @(negedge clk25);
    vif.inX       = 10'(x);
    vif.inY       = 10'(y);
    vif.inRequest = req;
    vif.swapReq   = swp;
    #1;
    fs      = req && (x == 0) && (y == 0);
    peff    = (m_pending && fs) ? ~m_page : m_page;
    in_area = req && ((x >> 2) < 160) && ((y >> 2) < 120);
    a       = in_area ? (int'(peff) * 19200 + (y >> 2) * 160 + (x >> 2)) : 0;
    chk("addr_model", 32'(vif.memAddr), 32'(a));
    if (exp_addr >= 0) chk("addr_directed", 32'(vif.memAddr), 32'(exp_addr));
    e = !req ? 24'h000000 : (!in_area ? BORDER : expand(mem[a]));
    exp_q.push_back(e);
    m_ack = m_pending && fs;
    if (m_pending && fs) begin
      m_page    = ~m_page;
      m_pending = 1'b0;
    end else if (!m_pending && swp) begin
      m_pending = 1'b1;
    end
    @(posedge clk25);
    #1;
    chk("page", 32'(vif.page), 32'(m_page));
    chk("swap_ack", 32'(vif.swapAck), 32'(m_ack));
    if (exp_q.size() >= 2) chk("rgb", rgb_now(), 32'(exp_q.pop_front()));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_page    = 1'b0;
    m_pending = 1'b0;
    m_ack     = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 37) ^ (i >> 7));
    mem[321] = 8'hE3;
    model_reset();

    // Reset held with request toggling: everything stays cleared.
    rstN          = 1'b0;
    vif.inX       = 10'd0;
    vif.inY       = 10'd0;
    vif.inRequest = 1'b0;
    vif.swapReq   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk25);
      vif.inRequest = ~vif.inRequest;
      vif.inX       = 10'(i * 4 + 4);
      #1;
      chk("rst_addr", 32'(vif.memAddr), 32'd0);
      @(posedge clk25);
      #1;
      chk("rst_rgb", rgb_now(), 32'd0);
      chk("rst_page", 32'(vif.page), 32'd0);
      chk("rst_ack", 32'(vif.swapAck), 32'd0);
    end
    @(negedge clk25);
    vif.inRequest = 1'b0;
    rstN          = 1'b1;
    model_reset();

    // Idle after release keeps black.
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, -1);

    // Pixel mapping (5,9) -> source (1,2) -> 321, data E3 -> FF00FF.
    step(5, 9, 1'b1, 1'b0, 321);
    step(0, 0, 1'b0, 1'b0, -1);
    chk("map_rgb", rgb_now(), 32'h00FF00FF);

    // Back-to-back requests then a gap.
    for (int x = 0; x < 4; x++) step(x, 4, 1'b1, 1'b0, -1);
    step(0, 0, 1'b0, 1'b0, -1);
    step(0, 0, 1'b0, 1'b0, -1);
    chk("gap_black", rgb_now(), 32'd0);

    // Area boundaries and out-of-range coordinates.
    step(640, 0, 1'b1, 1'b0, 0);
    step(639, 0, 1'b1, 1'b0, 159);
    chk("border_rgb", rgb_now(), 32'(BORDER));
    step(1023, 1023, 1'b1, 1'b0, 0);
    step(0, 480, 1'b1, 1'b0, 0);
    step(639, 479, 1'b1, 1'b0, 19199);
    step(0, 0, 1'b0, 1'b0, -1);

    // Swap requested mid-frame, applied only at (0,0).
    step(10, 10, 1'b1, 1'b1, -1);
    step(11, 10, 1'b1, 1'b1, -1);
    chk("swap_wait_page", 32'(vif.page), 32'd0);
    step(0, 0, 1'b1, 1'b1, 19200);
    chk("swap_page", 32'(vif.page), 32'd1);
    chk("swap_ack_pulse", 32'(vif.swapAck), 32'd1);
    step(1, 0, 1'b1, 1'b0, 19200);
    chk("swap_ack_drop", 32'(vif.swapAck), 32'd0);
    step(8, 4, 1'b1, 1'b0, 19200 + 160 + 2);
    step(0, 0, 1'b1, 1'b0, 19200);
    chk("swap_stay_page", 32'(vif.page), 32'd1);
    step(0, 0, 1'b0, 1'b0, -1);

    // Reset while a swap is pending: page returns to 0 and no flip follows.
    step(20, 20, 1'b1, 1'b1, -1);
    step(21, 20, 1'b1, 1'b0, -1);
    @(negedge clk25);
    rstN          = 1'b0;
    vif.inX       = 10'd40;
    vif.inY       = 10'd40;
    vif.inRequest = 1'b1;
    #1;
    chk("rst2_addr", 32'(vif.memAddr), 32'd0);
    chk("rst2_rgb", rgb_now(), 32'd0);
    chk("rst2_page", 32'(vif.page), 32'd0);
    @(posedge clk25);
    #1;
    chk("rst2_rgb_hold", rgb_now(), 32'd0);
    @(negedge clk25);
    vif.inRequest = 1'b0;
    rstN          = 1'b1;
    model_reset();
    step(0, 0, 1'b1, 1'b0, 0);
    chk("rst2_no_ack", 32'(vif.swapAck), 32'd0);
    step(4, 0, 1'b1, 1'b0, 1);
    step(0, 0, 1'b0, 1'b0, -1);
    step(0, 0, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pixel_source.md
Name: vga_pixel_source

Overview:
- Pixel responder for vgaController: answers each pixel request (outX/outY/outRequest) with RGB on the controller's inRed/inGreen/inBlue inputs.
- Reads a double-buffered, low-resolution RGB332 framebuffer from an external synchronous RAM, upscales it by 2^SCALE_SHIFT, expands to 24-bit colour and drives a border colour outside the source area.
- Page swap is a handshake with the game logic, applied only at frame start to prevent tearing.

Parameters:
- SRC_W, 160, framebuffer width in source pixels
- SRC_H, 120, framebuffer height in source pixels
- SCALE_SHIFT, 2, upscale factor log2 (screen px = source px << SCALE_SHIFT)
- ADDR_W, 16, RAM address width; must hold 2*SRC_W*SRC_H
- BORDER_RGB, 24'h000000, colour driven for requests outside the source area

Ports:
- clk25  in  1  25 MHz pixel clock
- rstN  in  1  asynchronous active-low reset
- inX  in  10  requested screen column (from controller outX)
- inY  in  10  requested screen row (from controller outY)
- inRequest  in  1  pixel request strobe (from controller outRequest)
- memAddr  out  ADDR_W  framebuffer RAM read address, combinational from inX/inY/page
- memData  in  8  RAM read data RGB332, valid 1 cycle after memAddr
- swapReq  in  1  level; request page flip at next frame start
- swapAck  out  1  one-cycle pulse when flip performed
- page  out  1  page currently being displayed
- outRed  out  8  red to controller inRed
- outGreen  out  8  green to controller inGreen
- outBlue  out  8  blue to controller inBlue

Behaviour:
- Reset (rstN low, async): outRed/outGreen/outBlue=0, page=0, swapPending=0, swapAck=0, pipeline valid/inArea flags=0; memAddr=0 while in reset.
- Source coords: sx=inX>>SCALE_SHIFT, sy=inY>>SCALE_SHIFT; inArea = inRequest && sx<SRC_W && sy<SRC_H.
- memAddr = pageEff*SRC_W*SRC_H + sy*SRC_W + sx when inArea, else 0. Constant multiplies only; widths sized to ADDR_W with no truncation for legal parameters.
- Latency is exactly 1 cycle: the request at cycle N produces RGB registered at N+1 edge. Stage regs: valid_q<=inRequest, inArea_q<=inArea.
- Output mux at N+1 (registered outputs, updated every cycle):
  - valid_q=0 -> 0,0,0
  - valid_q=1, inArea_q=0 -> BORDER_RGB
  - valid_q=1, inArea_q=1 -> RGB332 expansion: R={r3,r3,r3[2:1]}, G={g3,g3,g3[2:1]}, B={b2,b2,b2,b2}, where memData=RRRGGGBB.
- Swap state machine, states IDLE and PENDING:
  - IDLE: swapReq=1 -> PENDING (swapPending=1).
  - Frame start = inRequest && inX==0 && inY==0.
  - In PENDING at a frame start: page toggles. pageEff=~page is used combinationally for that same request's memAddr. swapAck pulses high for the next cycle; state returns to IDLE.
  - swapReq held high across the flip causes a new PENDING only after swapAck (ack cycle counts as IDLE). Game logic must drop swapReq on swapAck; a held request flips again the following frame.
  - Frame start in IDLE: no change. pageEff=page otherwise.
- Requests with inX/inY beyond 639/479 are legal and produce the border (inArea=0). No assumption of contiguous requests; gaps yield black.
- Reset mid-frame: all state cleared immediately; first request after release uses page 0.
- memData is ignored when inArea_q=0.

Test Plan:
- Reset: rstN low 100 ns with inRequest toggling -> all RGB=0, page=0, swapAck=0; after release idle inputs keep RGB=0.
- Pixel mapping: request (x=5,y=9), page 0 -> memAddr=2*160+1=321; return memData=8'hE3 -> next cycle RGB=FF,00,FF.
- Latency/black: request x=0..3 back-to-back then inRequest=0 -> RGB valid on cycles 1..4 after each request, then 0 on the cycle after request drops.
- Border: SRC_W=100, request x=400,y=0 -> memAddr=0, next cycle RGB=BORDER_RGB; x=399 -> in-area addr 99.
- Swap: page 0, assert swapReq mid-frame -> no change until request (0,0). That request's memAddr=19200; page=1; swapAck one pulse next cycle; deassert -> stays page 1 next frame.
- Reset during PENDING: swapReq pulse, then rstN low before frame start -> after release page=0, no swapAck at next (0,0).
